// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared types and byte-lane helpers for the store buffer
//   mem_size_t    : access size, encoded like funct3[1:0] (SB=00, SH=01, SW=10)
//   store_entry_t : one buffered store (valid, committed, addr, data, size, tag)
//   size_mask     : byte-enable mask for a size at a given addr[1:0]
//   lane_data     : low-aligned data replicated into every candidate byte lane
//   size_misaligned : true when an access is not naturally aligned
package store_pkg;

    typedef enum logic [1:0] {
        SB = 2'b00,
        SH = 2'b01,
        SW = 2'b10
    } mem_size_t;

    // Tags are trace-only; the entry carries a fixed-width field and narrower
    // ROB tags are zero-extended into it.
    localparam int MAX_TAG_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 committed;
        logic [31:0]          addr;
        logic [31:0]          data;
        mem_size_t            size;
        logic [MAX_TAG_W-1:0] tag;
    } store_entry_t;

    function automatic logic [3:0] size_mask(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SB:      size_mask = 4'b0001 << addr_lo;
            SH:      size_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SW:      size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    // Replication puts the low bytes in every lane the strobe could select,
    // so no shifter is needed.
    function automatic logic [31:0] lane_data(input mem_size_t size, input logic [31:0] data);
        case (size)
            SB:      lane_data = {4{data[7:0]}};
            SH:      lane_data = {2{data[15:0]}};
            default: lane_data = data;
        endcase
    endfunction

    // The unused encoding 11 is treated as misaligned so it is never stored.
    function automatic logic size_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SB:      size_misaligned = 1'b0;
            SH:      size_misaligned = addr_lo[0];
            SW:      size_misaligned = |addr_lo;
            default: size_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - converts a low-aligned store into memory byte lanes
//   size    : access size (mem_size_t encoding)
//   addr_lo : byte address bits [1:0]
//   data    : low-aligned store data
//   wstrb   : byte enables
//   wdata   : lane-aligned write data
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    assign wstrb = size_mask(mem_size_t'(size), addr_lo);
    assign wdata = lane_data(mem_size_t'(size), data);

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with commit, drain, flush and load forwarding
//   clk_in, rst_in                     : clock, synchronous active-high reset
//   enq_*                              : executed store in (valid/ready handshake)
//   commit_in, flush_in                : ROB commit of oldest uncommitted store, squash
//   ld_addr_in, ld_size_in, fwd_*      : same-cycle load forwarding query
//   mem_*                              : committed store drain to data memory
//   misalign_out                       : one-cycle pulse on a rejected misaligned store
//   empty_out                          : no entries held
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             enq_valid_in,
    output logic             enq_ready_out,
    input  logic [31:0]      enq_addr_in,
    input  logic [31:0]      enq_data_in,
    input  logic [1:0]       enq_size_in,
    input  logic [TAG_W-1:0] enq_tag_in,
    input  logic             commit_in,
    input  logic             flush_in,
    input  logic [31:0]      ld_addr_in,
    input  logic [1:0]       ld_size_in,
    output logic             fwd_hit_out,
    output logic [31:0]      fwd_data_out,
    output logic             fwd_stall_out,
    output logic             mem_we_out,
    input  logic             mem_ready_in,
    output logic [29:0]      mem_addr_out,
    output logic [31:0]      mem_wdata_out,
    output logic [3:0]       mem_wstrb_out,
    output logic             misalign_out,
    output logic             empty_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    store_entry_t entries [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] cptr;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] cptr_next;
    // count: all held entries; ccount: committed entries not yet drained.
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] ccount;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] ccount_next;
    logic             misalign_q;

    logic enq_try;
    logic enq_bad;
    logic push;
    logic pop;
    logic com;

    // Readiness is from registered count only; a same-cycle drain does not help.
    assign enq_ready_out = (count != FULL_COUNT);
    assign empty_out     = (count == '0);
    assign misalign_out  = misalign_q;

    assign enq_bad = size_misaligned(mem_size_t'(enq_size_in), enq_addr_in[1:0]);
    assign enq_try = enq_valid_in && enq_ready_out && !flush_in;
    assign push    = enq_try && !enq_bad;
    assign mem_we_out = entries[head].valid && entries[head].committed;
    assign pop     = mem_we_out && mem_ready_in;
    // Only registered-valid entries can commit, so a same-cycle enqueue is excluded.
    assign com     = commit_in && entries[cptr].valid && !entries[cptr].committed;
    assign cptr_next = com ? cptr + PTR_ONE : cptr;

    always_comb begin
        ccount_next = ccount;
        if (com && !pop) begin
            ccount_next = ccount + CNT_ONE;
        end else if (!com && pop) begin
            ccount_next = ccount - CNT_ONE;
        end
        // After a flush only committed entries remain.
        if (flush_in) begin
            count_next = ccount_next;
        end else if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (!push && pop) begin
            count_next = count - CNT_ONE;
        end else begin
            count_next = count;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head       <= '0;
            cptr       <= '0;
            tail       <= '0;
            count      <= '0;
            ccount     <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid     <= 1'b0;
                entries[i].committed <= 1'b0;
            end
        end else begin
            misalign_q <= enq_try && enq_bad;
            count      <= count_next;
            ccount     <= ccount_next;
            cptr       <= cptr_next;
            if (pop) begin
                entries[head].valid     <= 1'b0;
                entries[head].committed <= 1'b0;
                head                    <= head + PTR_ONE;
            end
            if (com) begin
                entries[cptr].committed <= 1'b1;
            end
            if (flush_in) begin
                tail <= cptr_next;
                for (int i = 0; i < DEPTH; i++) begin
                    // The entry committed this same cycle survives the flush.
                    if (entries[i].valid && !entries[i].committed &&
                        !(com && (PTR_W'(i) == cptr))) begin
                        entries[i].valid <= 1'b0;
                    end
                end
            end else if (push) begin
                entries[tail] <= '{valid:     1'b1,
                                   committed: 1'b0,
                                   addr:      enq_addr_in,
                                   data:      enq_data_in,
                                   size:      mem_size_t'(enq_size_in),
                                   tag:       MAX_TAG_W'(enq_tag_in)};
                tail <= tail + PTR_ONE;
            end
        end
    end

    store_lane_align u_drain_align (
        .size    (entries[head].size),
        .addr_lo (entries[head].addr[1:0]),
        .data    (entries[head].data),
        .wstrb   (mem_wstrb_out),
        .wdata   (mem_wdata_out)
    );
    assign mem_addr_out = entries[head].addr[31:2];

    // Forwarding: walk oldest to youngest so younger bytes overwrite older ones.
    logic [PTR_W-1:0] fwd_idx;
    logic [3:0]       fwd_smask;
    logic [31:0]      fwd_sdata;
    logic [3:0]       fwd_cov;
    logic [31:0]      fwd_merged;
    logic [3:0]       ld_mask;
    logic [3:0]       ld_covered;
    logic [31:0]      ld_byte_mask;

    always_comb begin
        fwd_idx    = '0;
        fwd_smask  = '0;
        fwd_sdata  = '0;
        fwd_cov    = '0;
        fwd_merged = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if (entries[fwd_idx].valid &&
                entries[fwd_idx].addr[31:2] == ld_addr_in[31:2]) begin
                fwd_smask = size_mask(entries[fwd_idx].size, entries[fwd_idx].addr[1:0]);
                fwd_sdata = lane_data(entries[fwd_idx].size, entries[fwd_idx].data);
                for (int b = 0; b < 4; b++) begin
                    if (fwd_smask[b]) begin
                        fwd_cov[b]          = 1'b1;
                        fwd_merged[8*b +: 8] = fwd_sdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign ld_mask      = size_mask(mem_size_t'(ld_size_in), ld_addr_in[1:0]);
    assign ld_covered   = fwd_cov & ld_mask;
    assign ld_byte_mask = {{8{ld_mask[3]}}, {8{ld_mask[2]}}, {8{ld_mask[1]}}, {8{ld_mask[0]}}};
    assign fwd_hit_out   = (ld_mask != 4'b0000) && (ld_covered == ld_mask);
    assign fwd_stall_out = (ld_covered != 4'b0000) && !fwd_hit_out;
    assign fwd_data_out  = fwd_hit_out ? (fwd_merged & ld_byte_mask) : 32'h0;

    // Tags are carried for trace visibility only.
    logic unused_tags;
    always_comb begin
        unused_tags = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_tags = unused_tags ^ (^entries[i].tag);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            assert (count <= FULL_COUNT);
            assert (ccount <= count);
            assert (!(pop && count == '0));
            assert (!(push && !pop && !flush_in && count == FULL_COUNT));
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized self-checking bench for store_buffer
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        enq_valid_in;
    logic        enq_ready_out;
    logic [31:0] enq_addr_in;
    logic [31:0] enq_data_in;
    logic [1:0]  enq_size_in;
    logic [3:0]  enq_tag_in;
    logic        commit_in;
    logic        flush_in;
    logic [31:0] ld_addr_in;
    logic [1:0]  ld_size_in;
    logic        fwd_hit_out;
    logic [31:0] fwd_data_out;
    logic        fwd_stall_out;
    logic        mem_we_out;
    logic        mem_ready_in;
    logic [29:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [3:0]  mem_wstrb_out;
    logic        misalign_out;
    logic        empty_out;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .enq_valid_in  (enq_valid_in),
        .enq_ready_out (enq_ready_out),
        .enq_addr_in   (enq_addr_in),
        .enq_data_in   (enq_data_in),
        .enq_size_in   (enq_size_in),
        .enq_tag_in    (enq_tag_in),
        .commit_in     (commit_in),
        .flush_in      (flush_in),
        .ld_addr_in    (ld_addr_in),
        .ld_size_in    (ld_size_in),
        .fwd_hit_out   (fwd_hit_out),
        .fwd_data_out  (fwd_data_out),
        .fwd_stall_out (fwd_stall_out),
        .mem_we_out    (mem_we_out),
        .mem_ready_in  (mem_ready_in),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_wstrb_out (mem_wstrb_out),
        .misalign_out  (misalign_out),
        .empty_out     (empty_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the buffer is a list of stores, oldest first.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        bit          committed;
    } mst_t;

    mst_t q[$];
    bit   exp_mis     = 1'b0;
    bit   model_valid = 1'b0;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_misal(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) || (s == 2'b11);
    endfunction

    task automatic check_outputs();
        bit [3:0]    strb;
        logic [31:0] wexp;
        logic [31:0] wmask;
        bit [3:0]    cov;
        bit [3:0]    lmask;
        bit [3:0]    covered;
        logic [31:0] mval;
        logic [31:0] fexp;
        bit          hit;
        bit          stall;
        bit          we;
        int          lane;
        if (!model_valid) return;
        check("enq_ready", enq_ready_out, q.size() != DEPTH);
        check("empty", empty_out, q.size() == 0);
        we = (q.size() > 0) && q[0].committed;
        check("mem_we", mem_we_out, we);
        if (we) begin
            strb = '0; wexp = '0; wmask = '0;
            for (int k = 0; k < nbytes(q[0].size); k++) begin
                lane = int'(q[0].addr[1:0]) + k;
                strb[lane] = 1'b1;
                wexp[8*lane +: 8] = q[0].data[8*k +: 8];
                wmask[8*lane +: 8] = 8'hFF;
            end
            check("mem_addr", {2'b00, mem_addr_out}, {2'b00, q[0].addr[31:2]});
            check("mem_wstrb", mem_wstrb_out, strb);
            check("mem_wdata", mem_wdata_out & wmask, wexp);
        end
        cov = '0; lmask = '0; mval = '0; fexp = '0;
        for (int k = 0; k < nbytes(ld_size_in); k++) lmask[int'(ld_addr_in[1:0]) + k] = 1'b1;
        foreach (q[j]) begin
            if (q[j].addr[31:2] == ld_addr_in[31:2]) begin
                for (int k = 0; k < nbytes(q[j].size); k++) begin
                    lane = int'(q[j].addr[1:0]) + k;
                    cov[lane] = 1'b1;
                    mval[8*lane +: 8] = q[j].data[8*k +: 8];
                end
            end
        end
        covered = cov & lmask;
        hit   = (lmask != 0) && (covered == lmask);
        stall = (covered != 0) && !hit;
        if (hit) for (int b = 0; b < 4; b++) if (lmask[b]) fexp[8*b +: 8] = mval[8*b +: 8];
        check("fwd_hit", fwd_hit_out, hit);
        check("fwd_stall", fwd_stall_out, stall);
        check("fwd_data", fwd_data_out, fexp);
        check("misalign", misalign_out, exp_mis);
    endtask

    task automatic update_model();
        bit   ready;
        bit   pop;
        mst_t kept[$];
        mst_t s;
        if (rst_in) begin
            q.delete();
            exp_mis = 1'b0;
            model_valid = 1'b1;
            return;
        end
        ready = q.size() != DEPTH;
        pop = (q.size() > 0) && q[0].committed && mem_ready_in;
        if (commit_in) begin
            foreach (q[j]) if (!q[j].committed) begin q[j].committed = 1'b1; break; end
        end
        if (pop) void'(q.pop_front());
        if (flush_in) begin
            foreach (q[j]) if (q[j].committed) kept.push_back(q[j]);
            q = kept;
        end
        exp_mis = 1'b0;
        if (!flush_in && enq_valid_in && ready) begin
            if (is_misal(enq_addr_in, enq_size_in)) begin
                exp_mis = 1'b1;
            end else begin
                s.addr = enq_addr_in; s.data = enq_data_in;
                s.size = enq_size_in; s.committed = 1'b0;
                q.push_back(s);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic set_idle();
        rst_in = 1'b0; enq_valid_in = 1'b0; enq_addr_in = '0; enq_data_in = '0;
        enq_size_in = 2'b10; enq_tag_in = '0; commit_in = 1'b0; flush_in = 1'b0;
        ld_addr_in = 32'h0000_F000; ld_size_in = 2'b10; mem_ready_in = 1'b0;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        enq_valid_in = 1'b1; enq_addr_in = a; enq_data_in = d; enq_size_in = s;
        enq_tag_in = enq_tag_in + 4'd1;
    endtask

    initial begin
        int lo;
        set_idle();
        rst_in = 1'b1;
        tick();
        tick();
        check("rst_ready", enq_ready_out, 1);
        check("rst_empty", empty_out, 1);
        check("rst_we", mem_we_out, 0);
        rst_in = 1'b0;

        // Single word store, commit, drain.
        enq(32'h100, 32'hDEADBEEF, 2'b10); tick();
        enq_valid_in = 1'b0; commit_in = 1'b1; tick();
        check("t1_we", mem_we_out, 1);
        check("t1_addr", {2'b00, mem_addr_out}, 32'h40);
        check("t1_strb", mem_wstrb_out, 4'hF);
        check("t1_wdata", mem_wdata_out, 32'hDEADBEEF);
        commit_in = 1'b0; mem_ready_in = 1'b1; tick();
        check("t1_empty", empty_out, 1);
        check("t1_we_off", mem_we_out, 0);
        mem_ready_in = 1'b0;

        // Partial and full forwarding from an uncommitted byte store.
        enq(32'h203, 32'h000000AB, 2'b00); tick();
        enq_valid_in = 1'b0; ld_addr_in = 32'h200; ld_size_in = 2'b10; #1;
        check("t2_stall", fwd_stall_out, 1);
        check("t2_nohit", fwd_hit_out, 0);
        ld_addr_in = 32'h203; ld_size_in = 2'b00; #1;
        check("t2_hit", fwd_hit_out, 1);
        check("t2_data", fwd_data_out, 32'hAB000000);
        commit_in = 1'b1; tick();
        commit_in = 1'b0; mem_ready_in = 1'b1; tick(); tick();
        mem_ready_in = 1'b0;

        // Fill to full, then push against a same-cycle drain.
        for (int i = 0; i < 4; i++) begin enq(32'h400 + 4 * i, 32'h1000 + i, 2'b10); tick(); end
        check("t3_full", enq_ready_out, 0);
        commit_in = 1'b1; enq(32'h480, 32'h77, 2'b10); tick();
        mem_ready_in = 1'b1; tick();
        check("t3_after_pop", enq_ready_out, 1);
        enq_valid_in = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t3_drained", empty_out, 1);
        commit_in = 1'b0; mem_ready_in = 1'b0;

        // Flush with same-cycle commit.
        enq(32'h500, 32'hA, 2'b10); tick();
        enq(32'h504, 32'hB, 2'b10); tick();
        enq(32'h508, 32'hC, 2'b10); tick();
        enq_valid_in = 1'b0; commit_in = 1'b1; tick();
        flush_in = 1'b1; tick();
        commit_in = 1'b0; flush_in = 1'b0; mem_ready_in = 1'b1; tick();
        check("t4_second", {2'b00, mem_addr_out}, 32'h504 >> 2);
        tick();
        check("t4_empty", empty_out, 1);
        mem_ready_in = 1'b0;

        // Misaligned halfword.
        enq(32'h101, 32'h1234, 2'b01); tick();
        enq_valid_in = 1'b0;
        check("t5_pulse", misalign_out, 1);
        check("t5_empty", empty_out, 1);
        tick();
        check("t5_pulse_end", misalign_out, 0);

        // Merged forwarding, then reset while draining.
        enq(32'h300, 32'h11223344, 2'b10); tick();
        enq(32'h301, 32'h55, 2'b00); tick();
        enq_valid_in = 1'b0; commit_in = 1'b1; tick(); tick();
        commit_in = 1'b0; ld_addr_in = 32'h300; ld_size_in = 2'b10; #1;
        check("t6_hit", fwd_hit_out, 1);
        check("t6_data", fwd_data_out, 32'h11225544);
        mem_ready_in = 1'b1; rst_in = 1'b1; tick();
        check("t6_we_rst", mem_we_out, 0);
        check("t6_empty_rst", empty_out, 1);
        set_idle();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            enq_valid_in = ($urandom_range(0, 99) < 60);
            enq_size_in  = 2'($urandom_range(0, 2));
            lo = (enq_size_in == 2'b00) ? $urandom_range(0, 3) :
                 (enq_size_in == 2'b01) ? 2 * $urandom_range(0, 1) : 0;
            if ($urandom_range(0, 9) == 0) lo = $urandom_range(0, 3);
            enq_addr_in  = 32'h600 + 4 * $urandom_range(0, 3) + lo;
            enq_data_in  = $urandom;
            enq_tag_in   = 4'($urandom);
            commit_in    = ($urandom_range(0, 99) < 45);
            flush_in     = ($urandom_range(0, 99) < 5);
            mem_ready_in = ($urandom_range(0, 99) < 50);
            rst_in       = ($urandom_range(0, 199) == 0);
            ld_size_in   = 2'($urandom_range(0, 2));
            lo = (ld_size_in == 2'b00) ? $urandom_range(0, 3) :
                 (ld_size_in == 2'b01) ? 2 * $urandom_range(0, 1) : 0;
            ld_addr_in   = 32'h600 + 4 * $urandom_range(0, 3) + lo;
            tick();
        end

        set_idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order store buffer between the store-address/data execution unit and data BRAM. It is the write-side counterpart of the load path.
- Holds executed stores until the ROB commits them, then drains committed stores to memory one per cycle.
- Answers same-cycle forwarding queries from the load unit.
- A mispredict flush squashes uncommitted stores.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- TAG_W, 4, ROB tag width.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- enq_valid_in  in  1  executed store presented.
- enq_ready_out  out  1  buffer not full.
- enq_addr_in  in  32  byte address.
- enq_data_in  in  32  store data, low-aligned.
- enq_size_in  in  2  mem_size_t: SB=00, SH=01, SW=10.
- enq_tag_in  in  TAG_W  ROB tag, for debug/trace only.
- commit_in  in  1  ROB commits the oldest uncommitted store.
- flush_in  in  1  squash all uncommitted entries.
- ld_addr_in  in  32  load byte address.
- ld_size_in  in  2  load size.
- fwd_hit_out  out  1  load fully covered by buffered bytes.
- fwd_data_out  out  32  forwarded word, byte-lane aligned, i.e. word-shaped like a memory read.
- fwd_stall_out  out  1  partial overlap; load must retry.
- mem_we_out  out  1  write request.
- mem_ready_in  in  1  memory accepts the write this cycle.
- mem_addr_out  out  30  word address, equal to addr[31:2].
- mem_wdata_out  out  32  lane-shifted data.
- mem_wstrb_out  out  4  byte enables.
- misalign_out  out  1  one-cycle pulse on a rejected misaligned enqueue.
- empty_out  out  1  no entries held.

Behaviour:
- Storage: circular FIFO with head, commit and tail pointers, each log2(DEPTH) bits, plus a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Reset: head, commit and tail pointers and count go to 0. All valid and committed bits clear.
- Output values during reset (sampled on the edge after rst_in is seen): enq_ready_out=1, empty_out=1, mem_we_out=0, fwd_hit_out=0, fwd_stall_out=0, misalign_out=0.
- Enqueue: accepted when enq_valid_in and enq_ready_out are both high. enq_ready_out = (count != DEPTH) and is based on registered state only, so a drain in the same cycle does not free a slot for that enqueue.
- The entry is written at the tail and becomes visible to forwarding and drain logic the next cycle.
- Misaligned enqueue (SH with addr[0]=1, or SW with addr[1:0]!=0): not stored; misalign_out pulses high for 1 cycle.
- Commit: commit_in sets the committed bit of the entry at the commit pointer and advances that pointer.
  - commit_in while no uncommitted entry exists is ignored.
  - An entry enqueued in the same cycle cannot be committed in that cycle.
- Drain: mem_we_out = (head entry valid and committed), combinational from registered state.
  - mem_addr, mem_wdata and mem_wstrb are derived from the head entry. Strobes: SB gives 1 shifted by addr[1:0]; SH gives 0011 or 1100; SW gives 1111. Data is replicated or shifted into the lane.
  - The head pops when mem_we_out and mem_ready_in are both high.
  - Commit in cycle N gives mem_we_out=1 in cycle N+1 at the earliest.
- Flush: flush_in sets tail to the commit pointer and invalidates every uncommitted entry. Committed entries remain and keep draining.
  - Flush wins over an enqueue in the same cycle; the enqueue is dropped and does not raise misalign_out.
  - A commit in the same cycle is applied before the flush, so that entry survives.
- Forwarding (combinational): considers valid entries, committed or not, whose word address matches the load's word address.
  - The load byte mask is computed the same way as store strobes.
  - Entries are merged oldest to youngest, so the youngest write wins per byte.
  - fwd_hit_out = 1 when every load byte is covered.
  - fwd_stall_out = 1 when some but not all load bytes are covered.
  - With no overlap, both are 0 and fwd_data_out=0.
  - An entry popping in the current cycle still participates in forwarding.
- Full plus simultaneous pop: count is unchanged only if an enqueue also occurred. Count is never allowed to exceed DEPTH or go below 0; assert both.
- Reset mid-drain: mem_we_out is 0 the cycle after the reset edge, and any in-flight entry is discarded.
- empty_out = (count == 0).

Decomposition:
- Package store_pkg contains:
  - mem_size_t enum (SB, SH, SW), encoded to match funct3[1:0].
  - store_entry_t struct: valid, committed, addr[31:0], data[31:0], size, tag.
  - Function size_mask(size, addr_lo), returning a 4-bit byte mask.
- Sub-module store_lane_align (combinational): size, addr[1:0], data in; wstrb and lane-shifted wdata out. Instantiated once for drain; shared by forwarding via the package function.

Test Plan:
- Reset then SW 0x100 data 0xDEADBEEF, commit, mem_ready_in=1 -> mem_we_out high 1 cycle with mem_addr_out=0x40, wstrb=1111, wdata=0xDEADBEEF; then empty_out=1.
- SB 0x203 data 0xAB, no commit; load LW 0x200 -> fwd_stall_out=1. Load LB 0x203 -> fwd_hit_out=1, fwd_data_out=0xAB000000.
- Fill 4 stores while mem_ready_in=0 -> enq_ready_out=0. Further enq_valid_in with simultaneous commit/drain -> rejected; count stays at or below 4.
- Enqueue A, B, C; commit A; flush_in asserted together with commit_in for B -> A and B drain in order, C is never written, tail equals commit pointer.
- SH to 0x101 -> misalign_out pulses once, count unchanged, no mem_we_out.
- SW 0x300 = 0x11223344 then SB 0x301 = 0x55, both committed; LW 0x300 -> fwd_hit_out=1, fwd_data_out=0x11225544. Assert rst_in during the drain of the first store -> mem_we_out=0 next cycle, empty_out=1.
